// File: rtl/pwm_pkg.sv
// Shared constants for the PWM timebase: register map, CTRL field
// positions and reset values.
package pwm_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_DUTY   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_PRE_LSB = 8;

  // Reset values; multi-bit registers replicate these fill bits across their width.
  localparam logic RST_ENABLE      = 1'b0;
  localparam logic RST_TICK        = 1'b0;
  localparam logic RST_COUNT_FILL  = 1'b0;
  localparam logic RST_PERIOD_FILL = 1'b1;
  localparam logic RST_DUTY_FILL   = 1'b0;
  localparam logic RST_PRESC_FILL  = 1'b0;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock-enable generator: step pulses once every (prescale+1) cycles while
// enabled; the divider restarts from zero whenever the timebase is disabled.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [PRE_W-1:0] prescale,
  output logic             step
);

  logic [PRE_W-1:0] presc_cnt_q;
  logic [PRE_W-1:0] presc_cnt_d;
  logic             step_int;

  assign step_int = enable && (presc_cnt_q == prescale);
  assign step     = step_int;

  always_comb begin
    presc_cnt_d = presc_cnt_q + 1'b1;
    if (!enable || step_int) begin
      presc_cnt_d = {PRE_W{RST_PRESC_FILL}};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_cnt_q <= {PRE_W{RST_PRESC_FILL}};
    end else begin
      presc_cnt_q <= presc_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_timebase.sv
// PWM timebase: CTRL/PERIOD/DUTY register file, double-buffered period and
// duty, and a prescaled up-counter feeding the downstream comparator.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int W     = 8,
  parameter int PRE_W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         we,
  input  logic [1:0]   addr,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  output logic [W-1:0] count,
  output logic [W-1:0] duty,
  output logic         period_tick
);

  logic             enable_q,     enable_d;
  logic [PRE_W-1:0] prescale_q,   prescale_d;
  logic [W-1:0]     period_sh_q,  period_sh_d;
  logic [W-1:0]     period_act_q, period_act_d;
  logic [W-1:0]     duty_sh_q,    duty_sh_d;
  logic [W-1:0]     duty_act_q,   duty_act_d;
  logic [W-1:0]     count_q,      count_d;
  logic             tick_q,       tick_d;
  logic             step;
  logic [31:0]      rdata_c;

  wire unused_wdata = &{1'b0, wdata};

  pwm_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable_q),
    .prescale (prescale_q),
    .step     (step)
  );

  always_comb begin
    enable_d    = enable_q;
    prescale_d  = prescale_q;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    if (we) begin
      case (addr)
        ADDR_CTRL: begin
          enable_d   = wdata[CTRL_EN_BIT];
          prescale_d = wdata[CTRL_PRE_LSB +: PRE_W];
        end
        ADDR_PERIOD: period_sh_d = wdata[W-1:0];
        ADDR_DUTY:   duty_sh_d   = wdata[W-1:0];
        default: ;
      endcase
    end
  end

  // Active registers only ever load the pre-write shadow, so a write landing
  // on a wrap edge takes effect one period later.
  always_comb begin
    count_d      = count_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    tick_d       = 1'b0;
    if (!enable_q) begin
      period_act_d = period_sh_q;
      duty_act_d   = duty_sh_q;
    end else if (step) begin
      if (count_q == period_act_q) begin
        count_d      = {W{RST_COUNT_FILL}};
        period_act_d = period_sh_q;
        duty_act_d   = duty_sh_q;
        tick_d       = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable_q     <= RST_ENABLE;
      prescale_q   <= {PRE_W{RST_PRESC_FILL}};
      period_sh_q  <= {W{RST_PERIOD_FILL}};
      period_act_q <= {W{RST_PERIOD_FILL}};
      duty_sh_q    <= {W{RST_DUTY_FILL}};
      duty_act_q   <= {W{RST_DUTY_FILL}};
      count_q      <= {W{RST_COUNT_FILL}};
      tick_q       <= RST_TICK;
    end else begin
      enable_q     <= enable_d;
      prescale_q   <= prescale_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      duty_sh_q    <= duty_sh_d;
      duty_act_q   <= duty_act_d;
      count_q      <= count_d;
      tick_q       <= tick_d;
    end
  end

  always_comb begin
    rdata_c = '0;
    case (addr)
      ADDR_CTRL: begin
        rdata_c[CTRL_EN_BIT]                = enable_q;
        rdata_c[CTRL_PRE_LSB +: PRE_W]      = prescale_q;
      end
      ADDR_PERIOD: rdata_c[W-1:0] = period_sh_q;
      ADDR_DUTY:   rdata_c[W-1:0] = duty_sh_q;
      default: begin
        rdata_c[W-1:0] = count_q;
        rdata_c[W]     = tick_q;
      end
    endcase
  end

  assign rdata       = rdata_c;
  assign count       = count_q;
  assign duty        = duty_act_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_timebase.sv
// Self-checking bench for pwm_timebase: expected count/tick/duty come from
// closed-form period arithmetic measured from the enabling write.
module tb_pwm_timebase;

  localparam int W     = 8;
  localparam int PRE_W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         we = 1'b0;
  logic [1:0]   addr = 2'd0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic [W-1:0] count;
  logic [W-1:0] duty;
  logic         period_tick;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_timebase #(.W(W), .PRE_W(PRE_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .count       (count),
    .duty        (duty),
    .period_tick (period_tick)
  );

  // Cycle k counts from the first cycle after the enabling write.
  function automatic int exp_cnt(input int k, input int per, input int pre);
    return (k / (pre + 1)) % (per + 1);
  endfunction

  function automatic bit exp_tick(input int k, input int per, input int pre);
    return (k > 0) && ((k % ((per + 1) * (pre + 1))) == 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    we      = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    we      = 1'b0;
    step();
    step();
    n_cmp++;
    if (count !== 8'd0) begin $display("FAIL reset_count got %0d want 0", count); n_err++; end
    n_cmp++;
    if (duty !== 8'd0) begin $display("FAIL reset_duty got %0d want 0", duty); n_err++; end
    n_cmp++;
    if (period_tick !== 1'b0) begin $display("FAIL reset_tick got %b want 0", period_tick); n_err++; end
    addr = 2'd1; #1;
    n_cmp++;
    if (rdata !== 32'hFF) begin $display("FAIL reset_rd_period got %h want 000000ff", rdata); n_err++; end
    addr = 2'd0; #1;
    n_cmp++;
    if (rdata !== 32'h0) begin $display("FAIL reset_rd_ctrl got %h want 00000000", rdata); n_err++; end
    reset_n = 1'b1;
  endtask

  // Program, enable, then run n cycles; an optional duty write of d1 in cycle w
  // (w < 0 means none) must appear only at a tick cycle t >= w+2.
  task automatic run_trial(input string name, input int per, input int pre,
                           input int d0, input int d1, input int w, input int n);
    int ec;
    bit et;
    int ed;
    logic [31:0] ctrl;
    do_reset();
    wr(2'd1, 32'(per));
    wr(2'd2, 32'(d0));
    addr = 2'd1; #1;
    n_cmp++;
    if (rdata !== 32'(per)) begin $display("FAIL %s_rd_period got %h want %h", name, rdata, per); n_err++; end
    addr = 2'd2; #1;
    n_cmp++;
    if (rdata !== 32'(d0)) begin $display("FAIL %s_rd_duty got %h want %h", name, rdata, d0); n_err++; end
    ctrl = 32'((pre << 8) | 1);
    wr(2'd0, ctrl);
    addr = 2'd0; #1;
    n_cmp++;
    if (rdata !== ctrl) begin $display("FAIL %s_rd_ctrl got %h want %h", name, rdata, ctrl); n_err++; end
    addr = 2'd3;
    for (int k = 0; k < n; k++) begin
      #1;
      ec = exp_cnt(k, per, pre);
      et = exp_tick(k, per, pre);
      ed = d0;
      if (w >= 0) begin
        for (int t = w + 2; t <= k; t++) begin
          if (exp_tick(t, per, pre)) ed = d1;
        end
      end
      n_cmp++;
      if (count !== W'(ec)) begin $display("FAIL %s_count k=%0d got %0d want %0d", name, k, count, ec); n_err++; end
      n_cmp++;
      if (period_tick !== et) begin $display("FAIL %s_tick k=%0d got %b want %b", name, k, period_tick, et); n_err++; end
      n_cmp++;
      if (duty !== W'(ed)) begin $display("FAIL %s_duty k=%0d got %0d want %0d", name, k, duty, ed); n_err++; end
      if (addr == 2'd3) begin
        n_cmp++;
        if (rdata !== 32'((int'(et) << 8) | ec)) begin
          $display("FAIL %s_status k=%0d got %h want %h", name, k, rdata, (int'(et) << 8) | ec); n_err++;
        end
      end
      if (k == w) begin
        addr = 2'd2; wdata = 32'(d1); we = 1'b1;
      end else begin
        we = 1'b0; addr = 2'd3;
      end
      step();
    end
    we = 1'b0;
  endtask

  task automatic test_basic();
    run_trial("basic", 4, 0, 2, 2, -1, 15);
  endtask

  task automatic test_prescale();
    run_trial("prescale", 3, 2, 1, 1, -1, 30);
  endtask

  task automatic test_duty_update();
    run_trial("duty_mid", 4, 0, 2, 5, 1, 14);
    run_trial("duty_on_wrap", 4, 0, 2, 5, 4, 16);
  endtask

  task automatic test_period_zero();
    run_trial("period0", 0, 0, 3, 3, -1, 8);
  endtask

  task automatic test_pause();
    bit found = 1'b0;
    do_reset();
    wr(2'd1, 32'd7);
    wr(2'd0, 32'd1);
    for (int i = 0; i < 20 && !found; i++) begin
      if (count == 8'd2) found = 1'b1;
      else step();
    end
    n_cmp++;
    if (!found) begin $display("FAIL pause_wait got timeout want count=2"); n_err++; end
    wr(2'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (count !== 8'd3) begin $display("FAIL pause_hold i=%0d got %0d want 3", i, count); n_err++; end
      step();
    end
    wr(2'd0, 32'd1);
    n_cmp++;
    if (count !== 8'd3) begin $display("FAIL pause_resume0 got %0d want 3", count); n_err++; end
    step();
    n_cmp++;
    if (count !== 8'd4) begin $display("FAIL pause_resume1 got %0d want 4", count); n_err++; end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    do_reset();
    wr(2'd1, 32'd9);
    wr(2'd2, 32'd7);
    wr(2'd0, 32'd1);
    for (int i = 0; i < 30 && !found; i++) begin
      if (count == 8'd5) found = 1'b1;
      else step();
    end
    n_cmp++;
    if (!found) begin $display("FAIL rstmid_wait got timeout want count=5"); n_err++; end
    reset_n = 1'b0;
    we = 1'b1; addr = 2'd1; wdata = 32'd2;
    step();
    reset_n = 1'b1;
    we = 1'b0;
    n_cmp++;
    if (count !== 8'd0) begin $display("FAIL rstmid_count got %0d want 0", count); n_err++; end
    n_cmp++;
    if (duty !== 8'd0) begin $display("FAIL rstmid_duty got %0d want 0", duty); n_err++; end
    n_cmp++;
    if (period_tick !== 1'b0) begin $display("FAIL rstmid_tick got %b want 0", period_tick); n_err++; end
    #1;
    n_cmp++;
    if (rdata !== 32'hFF) begin $display("FAIL rstmid_rd_period got %h want 000000ff", rdata); n_err++; end
    addr = 2'd0; #1;
    n_cmp++;
    if (rdata !== 32'h0) begin $display("FAIL rstmid_rd_ctrl got %h want 00000000", rdata); n_err++; end
    step();
    n_cmp++;
    if (count !== 8'd0) begin $display("FAIL rstmid_disabled got %0d want 0", count); n_err++; end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_trial("random", int'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 30)), 50);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prescale();
    test_duty_update();
    test_period_zero();
    test_pause();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_timebase.md
# pwm_timebase

Upstream timebase for the PWM compare stage. Holds memory-mapped CTRL/PERIOD/DUTY registers written by the MIPS core. Runs a prescaled up-counter that wraps at a programmable period. Presents the registered counter value and the active duty value as the A/B operands of the downstream comparator, whose `A_less_B` becomes the PWM level. Period and duty are double-buffered so changes never glitch a running period.

## Interface
Parameters:
- `W`, default 8: counter, period and duty width.
- `PRE_W`, default 8: prescaler divide-value width.

Ports:
- `clk` in, 1: single system clock. All logic is on the rising edge.
- `reset_n` in, 1: reset. Synchronous, active-low.
- `we` in, 1: register write strobe, one cycle.
- `addr` in, 2: register select. 0 = CTRL, 1 = PERIOD, 2 = DUTY, 3 = STATUS (read-only).
- `wdata` in, 32: write data.
- `rdata` out, 32: combinational read of `addr`.
- `count` out, W: registered counter value. Comparator operand A.
- `duty` out, W: active duty value. Comparator operand B.
- `period_tick` out, 1: one-cycle pulse on counter wrap.

## Operation
- CTRL fields: bit 0 = `enable`; bits [8+PRE_W-1:8] = `prescale`.
- PERIOD and DUTY each write the shadow register from `wdata[W-1:0]`.
- Writes to STATUS are ignored.
- Readback:
  - CTRL returns `{zeros, prescale, 7'b0, enable}`.
  - PERIOD and DUTY return the shadow registers, zero-extended.
  - STATUS returns `{zeros, period_tick, count}`, with `count` in [W-1:0] and `period_tick` in bit W.
- Reset values: count=0, duty=0, period_tick=0, presc_cnt=0, enable=0, prescale=0, period shadow and active = {W{1'b1}}, duty shadow = 0.
- While disabled (`enable`=0):
  - count holds its value; presc_cnt is forced to 0.
  - Active period and duty copy their shadows every cycle, so the first enabled period uses the programmed values.
- While enabled, presc_cnt counts up.
  - When presc_cnt == prescale: presc_cnt returns to 0 and `step` asserts for one cycle.
  - prescale = 0 therefore gives a step every cycle.
- On `step`:
  - If count == active period: count <= 0, active period and duty load from their shadows, `period_tick` <= 1.
  - Otherwise count <= count + 1.
- `period_tick` is 0 in every cycle not immediately following a wrap step.
- Period 0: count stays 0, and every step is a wrap with a tick.
- Duty ≥ period+1 gives a comparator output of 100 % high; duty 0 gives 0 %.
- Write coinciding with a wrap step: active registers load the pre-write shadow value. The new value lands in the shadow and takes effect at the next wrap.
- Clearing `enable` mid-period: count freezes. Re-enabling resumes from the frozen count, with active registers refreshed from the shadows.
- `reset_n` low mid-period: every register returns to its reset value on that edge, regardless of `we`.

## Timing
- Register writes are visible on `rdata` the cycle after the `we` edge.
- `count` changes on the edge where `step` is high. Comparator operands are therefore stable for a full step interval.
- Period length = (period+1) × (prescale+1) clock cycles.
- `period_tick` is high in the cycle after the wrap edge, aligned with count=0 and with the new duty value.
- No combinational path from `wdata` to `count` or `duty`.

## Structure
- Package `pwm_pkg`:
  - Address constants `ADDR_CTRL`, `ADDR_PERIOD`, `ADDR_DUTY`, `ADDR_STATUS`.
  - CTRL bit positions `CTRL_EN_BIT` and `CTRL_PRE_LSB`.
  - Reset-value constants.
- Sub-module `pwm_prescaler`:
  - Ports: clk, reset_n, enable, prescale[PRE_W-1:0].
  - Output: `step`.
  - Contains presc_cnt and the clear-on-disable rule.
- The top level holds the register file, the shadow/active pair and the counter.

## Test plan
- Reset with `reset_n` = 0 for 2 cycles: count=0, duty=0, period_tick=0. Read PERIOD returns 0xFF, read CTRL returns 0.
- Write PERIOD=4, DUTY=2, CTRL=0x001: count sequence is 0,1,2,3,4,0,… every cycle. period_tick is high when count returns to 0; duty=2 throughout.
- CTRL=0x0201 (prescale=2) with PERIOD=3: each count value holds for 3 cycles; period_tick spacing is 12 cycles.
- While running with DUTY=2, write DUTY=5 at count=1: `duty` stays 2 until the wrap, then reads 5 when count=0. A write on the exact wrap-step cycle defers to the following wrap.
- PERIOD=0, enabled: count is constantly 0 and period_tick is high every cycle. Clear enable at count=3 with PERIOD=7: count holds at 3, and re-enabling continues with 4.
- Assert `reset_n` = 0 mid-count at count=5 with a simultaneous `we`: the next cycle has all outputs at their reset values and the write is discarded.
